nor_seq_ctrl: RTL

NOR_SEQ_CTRL -- requirements
Module: nor_seq_ctrl

---
 rtl/nor_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nor_seq_ctrl.sv
// Two-requester controller that serves boolean ops through one time-shared NOR gate.
// Requests are arbitrated round-robin; each op runs its NOR passes and then gives a one-cycle result strobe.
module nor_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic             a0,
  input  logic             b0,
  input  logic             a1,
  input  logic             b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             y,
  output logic             done_id,
  output logic             err,
  output logic [CNT_W-1:0] nor_cnt
);

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic             a_q, b_q, id_q;
  logic [2:0]       step_q;
  logic             t0_q, t1_q;
  logic             last_q;
  logic             done_q, y_q, err_q, id_out_q;
  logic [CNT_W-1:0] cnt_q;

  logic             any_req, take, sel_id, sel_a, sel_b, sel_legal, last_step;
  logic [2:0]       sel_op;
  logic             nor_x, nor_y, nor_out, wr_t0, wr_t1;

  function automatic logic [2:0] pass_count(input logic [2:0] op);
    case (op)
      OP_NOTA, OP_NOTB, OP_NOR: pass_count = 3'd1;
      OP_OR:                    pass_count = 3'd2;
      OP_AND:                   pass_count = 3'd3;
      OP_NAND:                  pass_count = 3'd4;
      default:                  pass_count = 3'd0;
    endcase
  endfunction

  // Round-robin: with both pending, the requester not served last wins.
  always_comb begin
    any_req   = req0 | req1;
    sel_id    = (req0 & req1) ? ~last_q : req1;
    sel_op    = sel_id ? op1 : op0;
    sel_a     = sel_id ? a1 : a0;
    sel_b     = sel_id ? b1 : b0;
    sel_legal = (pass_count(sel_op) != 3'd0);
    take      = (state == IDLE) & any_req;
  end

  assign gnt0 = take & ~rst & ~sel_id;
  assign gnt1 = take & ~rst & sel_id;
  assign busy = (state != IDLE);

  // Operand steering for the single NOR: each op is a fixed pass schedule.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise paths that skip an assignment infer latches.
    nor_x = 1'b0;
    nor_y = 1'b0;
    wr_t0 = 1'b0;
    wr_t1 = 1'b0;
    case (op_q)
      OP_NOTA: begin nor_x = a_q; nor_y = a_q; end
      OP_NOTB: begin nor_x = b_q; nor_y = b_q; end
      OP_NOR:  begin nor_x = a_q; nor_y = b_q; end
      OP_OR: begin
        if (step_q == 3'd0) begin
          nor_x = a_q; nor_y = b_q; wr_t0 = 1'b1;
        end else begin
          nor_x = t0_q; nor_y = t0_q;
        end
      end
      OP_AND, OP_NAND: begin
        case (step_q)
          3'd0:    begin nor_x = a_q;  nor_y = a_q;  wr_t0 = 1'b1; end
          3'd1:    begin nor_x = b_q;  nor_y = b_q;  wr_t1 = 1'b1; end
          3'd2:    begin nor_x = t0_q; nor_y = t1_q; wr_t0 = 1'b1; end
          default: begin nor_x = t0_q; nor_y = t0_q; end
        endcase
      end
      default: ;
    endcase
  end

  assign nor_out   = ~(nor_x | nor_y);
  assign last_step = (step_q == pass_count(op_q) - 3'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = sel_legal ? EVAL : DONE;
      EVAL:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses nonblocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      op_q     <= 3'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      id_q     <= 1'b0;
      step_q   <= 3'd0;
      t0_q     <= 1'b0;
      t1_q     <= 1'b0;
      last_q   <= 1'b1;
      done_q   <= 1'b0;
      y_q      <= 1'b0;
      err_q    <= 1'b0;
      id_out_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      done_q   <= 1'b0;
      y_q      <= 1'b0;
      err_q    <= 1'b0;
      id_out_q <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= sel_id;
            last_q <= sel_id;
            step_q <= 3'd0;
            if (!sel_legal) begin
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              id_out_q <= sel_id;
            end
          end
        end
        EVAL: begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
          step_q <= step_q + 3'd1;
          if (wr_t0) t0_q <= nor_out;
          if (wr_t1) t1_q <= nor_out;
          if (last_step) begin
            done_q   <= 1'b1;
            y_q      <= nor_out;
            id_out_q <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign y       = y_q;
  assign err     = err_q;
  assign done_id = id_out_q;
  assign nor_cnt = cnt_q;

endmodule
